// File: rtl/board_renderer.sv
// Board renderer: snapshots a multi-bit-per-cell board and sweeps the screen
// region (border ring + cells) one registered pixel per cycle.
module board_renderer #(
  parameter int COLS        = 10,
  parameter int ROWS        = 20,
  parameter int CELL_W      = 5,
  parameter int CELL_H      = 5,
  parameter int BORDER      = 1,
  parameter int X_OFF       = 40,
  parameter int Y_OFF       = 8,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int CELL_BITS   = 3,
  parameter int COLOUR_BITS = 3,
  parameter logic [COLOUR_BITS-1:0] BG_COLOUR     = COLOUR_BITS'(3'b000),
  parameter logic [COLOUR_BITS-1:0] BORDER_COLOUR = COLOUR_BITS'(3'b111)
) (
  input  logic                           CLOCK_50,
  input  logic                           resetn,
  input  logic [COLS*ROWS*CELL_BITS-1:0] board,
  input  logic                           start,
  output logic [7:0]                     x,
  output logic [6:0]                     y,
  output logic [COLOUR_BITS-1:0]         colour,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int W   = COLS*CELL_W + 2*BORDER;
  localparam int H   = ROWS*CELL_H + 2*BORDER;
  localparam int RXW = $clog2(W+1);
  localparam int RYW = $clog2(H+1);
  localparam int SXW = $clog2(CELL_W+1);
  localparam int SYW = $clog2(CELL_H+1);
  localparam int CCW = $clog2(COLS+1);
  localparam int CRW = $clog2(ROWS+1);

  if (X_OFF + W > SCREEN_W || Y_OFF + H > SCREEN_H || CELL_BITS > COLOUR_BITS) begin : g_bad_cfg
    $error("board_renderer: region exceeds screen or CELL_BITS > COLOUR_BITS");
  end

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

  state_t                         state;
  logic                           pending;
  logic [COLS*ROWS*CELL_BITS-1:0] shadow;
  logic [RXW-1:0]                 rx;
  logic [RYW-1:0]                 ry;
  logic [SXW-1:0]                 sx;
  logic [SYW-1:0]                 sy;
  logic [CCW-1:0]                 cc;
  logic [CRW-1:0]                 cr;

  logic                   in_x, in_y, last_col, last_row;
  int                     cell_idx;
  logic [CELL_BITS-1:0]   code;
  logic [COLOUR_BITS-1:0] pix;

  // Cell counters only move inside the interior, so (cr,cc) index the
  // shadow directly without any divide by CELL_W/CELL_H.
  always_comb begin
    in_x     = (int'(rx) >= BORDER) && (int'(rx) < W - BORDER);
    in_y     = (int'(ry) >= BORDER) && (int'(ry) < H - BORDER);
    last_col = (int'(rx) == W - 1);
    last_row = (int'(ry) == H - 1);
    cell_idx = int'(cr) * COLS + int'(cc);
    code     = CELL_BITS'(shadow >> (cell_idx * CELL_BITS));
    pix      = BG_COLOUR;
    if (!(in_x && in_y))  pix = BORDER_COLOUR;
    else if (code != '0)  pix = COLOUR_BITS'(code);
  end

  always_ff @(posedge CLOCK_50)
    if (state == LATCH) shadow <= board;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state   <= IDLE;
      pending <= 1'b0;
      rx <= '0; ry <= '0; sx <= '0; sy <= '0; cc <= '0; cr <= '0;
      x <= '0; y <= '0; colour <= '0;
      plot <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) state <= LATCH;
        LATCH: begin
          rx <= '0; ry <= '0; sx <= '0; sy <= '0; cc <= '0; cr <= '0;
          busy  <= 1'b1;
          state <= DRAW;
          if (start) pending <= 1'b1;
        end
        DRAW: begin
          plot   <= 1'b1;
          x      <= 8'(X_OFF + int'(rx));
          y      <= 7'(Y_OFF + int'(ry));
          colour <= pix;
          if (start) pending <= 1'b1;
          if (last_col) begin
            rx <= '0;
            ry <= ry + 1'b1;
            sx <= '0;
            cc <= '0;
            if (in_y) begin
              if (int'(sy) == CELL_H - 1) begin
                sy <= '0;
                cr <= cr + 1'b1;
              end else begin
                sy <= sy + 1'b1;
              end
            end
            if (last_row) state <= DONE;
          end else begin
            rx <= rx + 1'b1;
            if (in_x) begin
              if (int'(sx) == CELL_W - 1) begin
                sx <= '0;
                cc <= cc + 1'b1;
              end else begin
                sx <= sx + 1'b1;
              end
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          // A request arriving in this very cycle is folded into the pending one.
          if (pending || start) begin
            pending <= 1'b0;
            state   <= LATCH;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: default geometry plus a borderless 6x6-cell variant.
module tb_board_renderer;

  logic         clk = 1'b0;
  logic         resetn;
  logic [599:0] board, board2;
  logic         start, start2;
  logic [7:0]   x, x2;
  logic [6:0]   y, y2;
  logic [2:0]   colour, colour2;
  logic         plot, busy, done, plot2, busy2, done2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  board_renderer u_dut (
    .CLOCK_50(clk), .resetn(resetn), .board(board), .start(start),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  board_renderer #(.BORDER(0), .CELL_W(6), .CELL_H(6), .X_OFF(0), .Y_OFF(0)) u_dut2 (
    .CLOCK_50(clk), .resetn(resetn), .board(board2), .start(start2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2)
  );

  // Pixel capture, sampled on the falling edge
  logic [2:0] fb  [0:255][0:127];
  logic [2:0] fb2 [0:255][0:127];
  int cyc = 0, plot_cnt = 0, run = 0, last_run = 0, run_start = 0, last_plot = 0;
  int done_cnt = 0, done_cyc = 0, prev_done_cyc = 0, c1_cnt = 0;
  int lx = 0, ly = 0, lc = 0;
  int plot_cnt2 = 0, run2 = 0, last_run2 = 0, done_cnt2 = 0, c7_cnt2 = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (plot) begin
      fb[x][y]  <= colour;
      plot_cnt  <= plot_cnt + 1;
      run       <= run + 1;
      if (run == 0) run_start <= cyc;
      last_plot <= cyc;
      lx <= int'(x); ly <= int'(y); lc <= int'(colour);
      if (colour == 3'd1) c1_cnt <= c1_cnt + 1;
    end else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
    if (done) begin
      done_cnt      <= done_cnt + 1;
      done_cyc      <= cyc;
      prev_done_cyc <= done_cyc;
    end
  end

  always @(negedge clk) begin
    if (plot2) begin
      fb2[x2][y2] <= colour2;
      plot_cnt2   <= plot_cnt2 + 1;
      run2        <= run2 + 1;
      if (colour2 == 3'd7) c7_cnt2 <= c7_cnt2 + 1;
    end else begin
      if (run2 != 0) last_run2 <= run2;
      run2 <= 0;
    end
    if (done2) done_cnt2 <= done_cnt2 + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input bit sel, input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if ((sel ? done_cnt2 : done_cnt) >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick(2);
    checks++; if (x !== 8'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x); end
    checks++; if (y !== 7'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (colour !== 3'd0) begin failures++; $display("FAIL reset_colour got=%0d exp=0", colour); end
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%0d exp=0", plot); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
    resetn = 1'b1; tick(2);
  endtask

  task automatic test_empty_board();
    int b_plot, b_done; bit ok;
    board = '0; b_plot = plot_cnt; b_done = done_cnt;
    pulse_start();
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL latch_plot got=%0d exp=0", plot); end
    tick(1);
    checks++; if (plot !== 1'b0) begin failures++; $display("FAIL pre_plot got=%0d exp=0", plot); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_busy got=%0d exp=1", busy); end
    tick(1);
    checks++; if (plot !== 1'b1) begin failures++; $display("FAIL first_plot got=%0d exp=1", plot); end
    checks++; if (x !== 8'd40 || y !== 7'd8) begin failures++; $display("FAIL first_xy got=(%0d,%0d) exp=(40,8)", x, y); end
    checks++; if (colour !== 3'd7) begin failures++; $display("FAIL first_colour got=%0d exp=7", colour); end
    wait_done(1'b0, b_done + 1, 6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL empty_timeout got=no_done exp=done"); end
    tick(3);
    checks++; if (plot_cnt - b_plot != 5304) begin failures++; $display("FAIL empty_plots got=%0d exp=5304", plot_cnt - b_plot); end
    checks++; if (last_run != 5304) begin failures++; $display("FAIL empty_run got=%0d exp=5304", last_run); end
    checks++; if (fb[41][9] !== 3'd0) begin failures++; $display("FAIL empty_41_9 got=%0d exp=0", fb[41][9]); end
    checks++; if (lx != 91 || ly != 109 || lc != 7) begin failures++; $display("FAIL empty_last got=(%0d,%0d,%0d) exp=(91,109,7)", lx, ly, lc); end
    checks++; if (done_cnt - b_done != 1) begin failures++; $display("FAIL empty_dones got=%0d exp=1", done_cnt - b_done); end
    checks++; if (done_cyc != last_plot + 1) begin failures++; $display("FAIL empty_done_lag got=%0d exp=1", done_cyc - last_plot); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy_after got=%0d exp=0", busy); end
  endtask

  task automatic test_cells();
    int bad2, bad5; bit ok;
    board = '0; board[2:0] = 3'b010; board[597 +: 3] = 3'b101;
    pulse_start();
    wait_done(1'b0, done_cnt + 1, 6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cells_timeout got=no_done exp=done"); end
    tick(3);
    bad2 = 0; bad5 = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        if (fb[41+i][9+j] !== 3'd2) bad2++;
        if (fb[86+i][104+j] !== 3'd5) bad5++;
      end
    checks++; if (bad2 != 0) begin failures++; $display("FAIL cell00_block got=%0d_bad exp=0_bad", bad2); end
    checks++; if (bad5 != 0) begin failures++; $display("FAIL cell19_9_block got=%0d_bad exp=0_bad", bad5); end
    checks++; if (fb[46][9] !== 3'd0) begin failures++; $display("FAIL cell_46_9 got=%0d exp=0", fb[46][9]); end
    checks++; if (fb[91][108] !== 3'd7) begin failures++; $display("FAIL right_border got=%0d exp=7", fb[91][108]); end
  endtask

  task automatic test_mid_change();
    int b_c1; bit ok;
    board = '0; b_c1 = c1_cnt;
    pulse_start();
    tick(1000);
    board = {200{3'b001}};
    wait_done(1'b0, done_cnt + 1, 6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=no_done exp=done"); end
    tick(3);
    checks++; if (c1_cnt != b_c1) begin failures++; $display("FAIL mid_colour1 got=%0d exp=0", c1_cnt - b_c1); end
    checks++; if (fb[41][9] !== 3'd0) begin failures++; $display("FAIL mid_old_pixel got=%0d exp=0", fb[41][9]); end
    pulse_start();
    wait_done(1'b0, done_cnt + 1, 6000, ok);
    tick(3);
    checks++; if (fb[41][9] !== 3'd1 || fb[90][108] !== 3'd1) begin failures++; $display("FAIL new_snapshot got=(%0d,%0d) exp=(1,1)", fb[41][9], fb[90][108]); end
    checks++; if (fb[40][8] !== 3'd7) begin failures++; $display("FAIL new_border got=%0d exp=7", fb[40][8]); end
  endtask

  task automatic test_back_to_back();
    int b_plot, b_done; bit ok;
    board = '0; b_plot = plot_cnt; b_done = done_cnt;
    pulse_start();
    tick(100);
    repeat (3) begin pulse_start(); tick(50); end
    wait_done(1'b0, b_done + 2, 12000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=no_second_done exp=done"); end
    tick(20);
    checks++; if (done_cnt - b_done != 2) begin failures++; $display("FAIL b2b_dones got=%0d exp=2", done_cnt - b_done); end
    checks++; if (plot_cnt - b_plot != 10608) begin failures++; $display("FAIL b2b_plots got=%0d exp=10608", plot_cnt - b_plot); end
    checks++; if (last_run != 5304) begin failures++; $display("FAIL b2b_run got=%0d exp=5304", last_run); end
    checks++; if (run_start != prev_done_cyc + 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2", run_start - prev_done_cyc); end
  endtask

  task automatic test_reset_mid();
    int b_plot, b_done; bit ok;
    board = '0; b_plot = plot_cnt; b_done = done_cnt; ok = 1'b0;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (plot_cnt - b_plot >= 1000) begin ok = 1'b1; break; end
      tick(1);
    end
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=%0d exp=1000", plot_cnt - b_plot); end
    resetn = 1'b0; tick(1); resetn = 1'b1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got=plot%0d_busy%0d exp=plot0_busy0", plot, busy); end
    checks++; if (x !== 8'd0 || y !== 7'd0) begin failures++; $display("FAIL rmid_xy got=(%0d,%0d) exp=(0,0)", x, y); end
    tick(50);
    checks++; if (done_cnt != b_done) begin failures++; $display("FAIL rmid_done got=%0d exp=0", done_cnt - b_done); end
    pulse_start();
    wait_done(1'b0, b_done + 1, 6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_restart_timeout got=no_done exp=done"); end
    tick(3);
    checks++; if (last_run != 5304) begin failures++; $display("FAIL rmid_restart_run got=%0d exp=5304", last_run); end
  endtask

  task automatic test_no_border();
    int b_plot, b_c7, bad; bit ok;
    board2 = '0; b_plot = plot_cnt2; b_c7 = c7_cnt2;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    wait_done(1'b1, done_cnt2 + 1, 9000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nb_timeout got=no_done exp=done"); end
    tick(3);
    checks++; if (plot_cnt2 - b_plot != 7200) begin failures++; $display("FAIL nb_plots got=%0d exp=7200", plot_cnt2 - b_plot); end
    checks++; if (last_run2 != 7200) begin failures++; $display("FAIL nb_run got=%0d exp=7200", last_run2); end
    checks++; if (c7_cnt2 != b_c7) begin failures++; $display("FAIL nb_colour7 got=%0d exp=0", c7_cnt2 - b_c7); end
    board2[69 +: 3] = 3'b100;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    wait_done(1'b1, done_cnt2 + 1, 9000, ok);
    tick(3);
    bad = 0;
    for (int i = 18; i <= 23; i++)
      for (int j = 12; j <= 17; j++)
        if (fb2[i][j] !== 3'd4) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL nb_cell2_3 got=%0d_bad exp=0_bad", bad); end
    checks++; if (fb2[17][12] !== 3'd0 || fb2[24][17] !== 3'd0) begin failures++; $display("FAIL nb_cell_xedge got=(%0d,%0d) exp=(0,0)", fb2[17][12], fb2[24][17]); end
    checks++; if (fb2[18][11] !== 3'd0 || fb2[23][18] !== 3'd0) begin failures++; $display("FAIL nb_cell_yedge got=(%0d,%0d) exp=(0,0)", fb2[18][11], fb2[23][18]); end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; start2 = 1'b0; board = '0; board2 = '0;
    tick(2);
    test_reset();
    test_empty_board();
    test_cells();
    test_mid_change();
    test_back_to_back();
    test_reset_mid();
    test_no_border();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
